// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan controller.
// Optional feature macro: HUB75_BRIGHTNESS_EN (adds the brightness input).
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_TOP,
    RD_BOT,
    CLK_LO,
    CLK_HI,
    LATCH,
    SHOW
  } state_e;

  localparam int ADDR_W = 14;

  // Channel index within a pixel word; bit for plane k is CH*BPC + k.
  localparam int R_CH = 2;
  localparam int G_CH = 1;
  localparam int B_CH = 0;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-code-modulation tick counter for the SHOW phase.
// With HUB75_BRIGHTNESS_EN defined, also reports the brightness cutoff.
module hub75_bcm_timer #(
  parameter int BASE_TICKS = 8,
  parameter int BPC        = 4,
  parameter int PW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [PW-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          last,
  output logic          lit_next
);

  localparam int TW = $clog2(BASE_TICKS << (BPC - 1)) + 1;

  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] dur;

  always_comb begin
    dur    = TW'(BASE_TICKS) << plane;
    last   = run && (tick_q == dur - TW'(1));
    tick_d = (run && !last) ? tick_q + TW'(1) : '0;
  end

`ifdef HUB75_BRIGHTNESS_EN
  localparam int PRW = TW + 9;
  logic [PRW-1:0] prod;
  logic [PRW-1:0] thr;

  // lit_next describes the tick the counter will hold next cycle,
  // so the registered oe lines up with that tick.
  always_comb begin
    prod     = PRW'(dur) * PRW'({1'b0, brightness} + 9'd1);
    thr      = prod >> 8;
    lit_next = PRW'(tick_d) < thr;
  end
`else
  assign lit_next = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: shifts two rows per scan line, latches, then shows with BCM timing.
// Optional feature macro: HUB75_BRIGHTNESS_EN (global brightness via oe duty).
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 64,
  parameter int BPP        = 12,
  parameter int BPC        = 4,
  parameter int CHAINED    = 1,
  parameter int BASE_TICKS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [BPP-1:0]    mem_data,
  output logic              sclk,
  output logic              lat,
  output logic              oe,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              frame_done
);

  localparam int COLS = WIDTH * CHAINED;
  localparam int ROWS = HEIGHT / 2;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW   = (BPC > 1) ? $clog2(BPC) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [PW-1:0]     plane_q, plane_d;
  logic              sclk_q, sclk_d;
  logic              lat_q, lat_d;
  logic              oe_q, oe_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [4:0]        rowsel_q, rowsel_d;
  logic [2:0]        top_rgb_q, top_rgb_d;
  logic [2:0]        bot_rgb_q, bot_rgb_d;
  logic              frame_done_q, frame_done_d;

  logic              tmr_last;
  logic              tmr_lit_next;

  logic [BPC-1:0]    r_pl, g_pl, b_pl;
  logic [2:0]        plane_rgb;

  for (genvar gi = 0; gi < BPC; gi++) begin : g_plane
    assign r_pl[gi] = mem_data[R_CH*BPC + gi];
    assign g_pl[gi] = mem_data[G_CH*BPC + gi];
    assign b_pl[gi] = mem_data[B_CH*BPC + gi];
  end

  assign plane_rgb = {r_pl[plane_q], g_pl[plane_q], b_pl[plane_q]};

  hub75_bcm_timer #(
    .BASE_TICKS (BASE_TICKS),
    .BPC        (BPC),
    .PW         (PW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (state_q == SHOW),
    .plane      (plane_q),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .last       (tmr_last),
    .lit_next   (tmr_lit_next)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    plane_d      = plane_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RD_TOP;
          col_d   = '0;
          row_d   = '0;
          plane_d = '0;
        end
      end
      RD_TOP: state_d = RD_BOT;
      RD_BOT: state_d = CLK_LO;
      CLK_LO: state_d = CLK_HI;
      CLK_HI: begin
        if (col_q == CW'(COLS - 1)) begin
          state_d = LATCH;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = RD_TOP;
        end
      end
      LATCH: begin
        col_d   = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (tmr_last) begin
          if (plane_q == PW'(BPC - 1)) begin
            plane_d = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            plane_d = plane_q + PW'(1);
          end
          state_d = en ? RD_TOP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Panel-facing outputs are decoded from the next state and registered,
    // so they are aligned with state_q and never combinational from inputs.
    sclk_d   = (state_d == CLK_HI);
    lat_d    = (state_d == LATCH);
    oe_d     = !((state_d == SHOW) && tmr_lit_next);
    mem_re_d = (state_d == RD_TOP) || (state_d == RD_BOT);

    mem_addr_d = mem_addr_q;
    if (state_d == RD_TOP) begin
      mem_addr_d = ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d);
    end else if (state_d == RD_BOT) begin
      mem_addr_d = (ADDR_W'(row_d) + ADDR_W'(ROWS)) * ADDR_W'(COLS) + ADDR_W'(col_d);
    end

    rowsel_d = rowsel_q;
    if (state_d == LATCH) begin
      rowsel_d = 5'(row_q);
      if (ROWS <= 16) begin
        rowsel_d[4] = 1'b0;
      end
    end

    // Read data trails mem_re by one cycle: top pixel arrives in RD_BOT,
    // bottom pixel in CLK_LO.
    top_rgb_d = (state_q == RD_BOT) ? plane_rgb : top_rgb_q;
    bot_rgb_d = (state_q == CLK_LO) ? plane_rgb : bot_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      rowsel_q     <= '0;
      top_rgb_q    <= '0;
      bot_rgb_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      rowsel_q     <= rowsel_d;
      top_rgb_q    <= top_rgb_d;
      bot_rgb_q    <= bot_rgb_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe         = oe_q;
  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign {e, d, c, b, a} = rowsel_q;
  assign {r0, g0, b0} = top_rgb_q;
  assign {r1, g1, b1} = bot_rgb_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl on a 4x4 panel, 2 planes, BASE_TICKS=2.
// Honours HUB75_BRIGHTNESS_EN when defined.
module tb_hub75_scan_ctrl;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int BPPV = 12;
  localparam int BPCV = 2;
  localparam int CHN  = 1;
  localparam int BT   = 2;
  localparam int COLS = W * CHN;
  localparam int ROWS = H / 2;
`ifdef HUB75_BRIGHTNESS_EN
  localparam bit BRI_EN = 1'b1;
`else
  localparam bit BRI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  bri = 8'd127;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic [11:0] mem_data = '0;
  logic        sclk, lat, oe;
  logic        a_ln, b_ln, c_ln, d_ln, e_ln;
  logic        r0, g0, b0, r1, g1, b1;
  logic        frame_done;

  logic [11:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_data <= mem[mem_addr[3:0]];
  end

  hub75_scan_ctrl #(
    .WIDTH(W), .HEIGHT(H), .BPP(BPPV), .BPC(BPCV), .CHAINED(CHN), .BASE_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(bri),
`endif
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_data(mem_data),
    .sclk(sclk), .lat(lat), .oe(oe),
    .a(a_ln), .b(b_ln), .c(c_ln), .d(d_ln), .e(e_ln),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .frame_done(frame_done)
  );

  typedef struct {
    bit       re;
    int       addr;
    bit       sclk;
    bit       lat;
    bit       oe;
    bit       fd;
    bit       has_rgb;
    bit [5:0] rgb;
    bit       has_row;
    int       row;
    int       plane;
  } exp_t;

  function automatic int blk_len(int p);
    return 4 * COLS + 1 + (BT << p);
  endfunction

  function automatic bit lit(int i, int p);
    return !BRI_EN || (i < (((BT << p) * (int'(bri) + 1)) >> 8));
  endfunction

  // Expected outputs u cycles after scanning starts, with en held high.
  function automatic exp_t model(int u);
    exp_t x;
    int rlen, flen, f, r, w, p, s, col;
    logic [11:0] tp, bp;
    x = '{default: 0};
    x.oe = 1'b1;
    rlen = 0;
    for (int k = 0; k < BPCV; k++) rlen += blk_len(k);
    flen = rlen * ROWS;
    x.fd = (u > 0) && (u % flen == 0);
    f = u % flen;
    r = f / rlen;
    w = f % rlen;
    p = 0;
    while (w >= blk_len(p)) begin
      w -= blk_len(p);
      p++;
    end
    s = w;
    x.row = r;
    x.plane = p;
    if (s < 4 * COLS) begin
      col = s / 4;
      case (s % 4)
        0: begin x.re = 1'b1; x.addr = r * COLS + col; end
        1: begin x.re = 1'b1; x.addr = (r + ROWS) * COLS + col; end
        3: begin
          x.sclk = 1'b1;
          x.has_rgb = 1'b1;
          tp = mem[r * COLS + col];
          bp = mem[(r + ROWS) * COLS + col];
          x.rgb = {tp[2*BPCV+p], tp[BPCV+p], tp[p], bp[2*BPCV+p], bp[BPCV+p], bp[p]};
        end
        default: ;
      endcase
    end else if (s == 4 * COLS) begin
      x.lat = 1'b1;
      x.has_row = 1'b1;
    end else begin
      x.oe = !lit(s - 4 * COLS - 1, p);
    end
    return x;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
  endtask

  // Holds reset for a few cycles, then releases it on a falling edge;
  // the next falling edge is scan cycle t=1.
  task automatic start_scan();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (oe !== 1'b1 || lat !== 1'b0 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: oe=%b lat=%b sclk=%b, required oe=1 lat=0 sclk=0", oe, lat, sclk);
    end
    checks++;
    if (mem_re !== 1'b0 || mem_addr !== 14'd0) begin
      errors++;
      $display("FAIL reset_mem: mem_re=%b mem_addr=%0d, required 0 and 0", mem_re, mem_addr);
    end
    checks++;
    if ({e_ln, d_ln, c_ln, b_ln, a_ln} !== 5'd0 || {r0, g0, b0, r1, g1, b1} !== 6'd0) begin
      errors++;
      $display("FAIL reset_lines: rows=%b rgb=%b, required all zero",
               {e_ln, d_ln, c_ln, b_ln, a_ln}, {r0, g0, b0, r1, g1, b1});
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd: frame_done=%b, required 0", frame_done);
    end
    $display("reset state sampled");
  endtask

  // Two full frames with en held high, every cycle checked against the model.
  task automatic test_frame(input logic [7:0] bri_in);
    exp_t x;
    int rlen, flen, fd_cnt;
    bri = bri_in;
    fill_mem();
    rlen = 0;
    for (int k = 0; k < BPCV; k++) rlen += blk_len(k);
    flen = rlen * ROWS;
    fd_cnt = 0;
    start_scan();
    for (int t = 1; t <= 2 * flen; t++) begin
      @(negedge clk);
      x = model(t - 1);
      if (frame_done === 1'b1) fd_cnt++;
      checks++;
      if (mem_re !== x.re || (x.re && mem_addr !== 14'(x.addr))) begin
        errors++;
        if (errors < 40)
          $display("FAIL frame_mem t=%0d: mem_re=%b addr=%0d, required mem_re=%b addr=%0d",
                   t, mem_re, mem_addr, x.re, x.addr);
      end
      checks++;
      if (sclk !== x.sclk || lat !== x.lat || oe !== x.oe || frame_done !== x.fd) begin
        errors++;
        if (errors < 40)
          $display("FAIL frame_ctrl t=%0d: sclk=%b lat=%b oe=%b fd=%b, required %b %b %b %b",
                   t, sclk, lat, oe, frame_done, x.sclk, x.lat, x.oe, x.fd);
      end
      if (x.has_rgb) begin
        checks++;
        if ({r0, g0, b0, r1, g1, b1} !== x.rgb) begin
          errors++;
          if (errors < 40)
            $display("FAIL frame_rgb t=%0d: rgb=%b, required %b", t, {r0, g0, b0, r1, g1, b1}, x.rgb);
        end
      end
      if (x.has_row) begin
        checks++;
        if ({e_ln, d_ln, c_ln, b_ln, a_ln} !== 5'(x.row)) begin
          errors++;
          $display("FAIL frame_row t=%0d: rows=%0d, required %0d", t, {e_ln, d_ln, c_ln, b_ln, a_ln}, x.row);
        end
        $display("latch row %0d plane %0d at t=%0d", x.row, x.plane, t);
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL frame_done_count: saw %0d pulses, required 1", fd_cnt);
    end
  endtask

  task automatic test_reset_mid_show();
    exp_t x;
    fill_mem();
    start_scan();
    // t=18 and t=19 are the first two SHOW cycles of row 0 plane 0.
    for (int t = 1; t <= 19; t++) @(negedge clk);
    x = model(18);
    checks++;
    if (oe !== x.oe || lat !== 1'b0) begin
      errors++;
      $display("FAIL midshow_pre: oe=%b lat=%b, required oe=%b lat=0", oe, lat, x.oe);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (oe !== 1'b1 || lat !== 1'b0 || sclk !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL midshow_rst: oe=%b lat=%b sclk=%b mem_re=%b, required 1 0 0 0", oe, lat, sclk, mem_re);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 14'd0) begin
      errors++;
      $display("FAIL midshow_restart: mem_re=%b addr=%0d, required 1 and 0", mem_re, mem_addr);
    end
    $display("reset during SHOW and restart sampled");
  endtask

  task automatic test_en_drop();
    exp_t x;
    int re_seen;
    fill_mem();
    start_scan();
    for (int t = 1; t <= 19; t++) begin
      @(negedge clk);
      x = model(t - 1);
      checks++;
      if (mem_re !== x.re || sclk !== x.sclk || lat !== x.lat || oe !== x.oe ||
          (x.re && mem_addr !== 14'(x.addr))) begin
        errors++;
        if (errors < 40)
          $display("FAIL endrop_row t=%0d: re=%b addr=%0d sclk=%b lat=%b oe=%b, required %b %0d %b %b %b",
                   t, mem_re, mem_addr, sclk, lat, oe, x.re, x.addr, x.sclk, x.lat, x.oe);
      end
      // t=4 is CLK_HI of column 0.
      if (t == 4) en = 1'b0;
    end
    re_seen = 0;
    for (int t = 20; t < 32; t++) begin
      @(negedge clk);
      if (mem_re !== 1'b0 || oe !== 1'b1) re_seen++;
    end
    checks++;
    if (re_seen != 0) begin
      errors++;
      $display("FAIL endrop_idle: %0d cycles with mem_re=1 or oe=0, required 0", re_seen);
    end
    $display("en drop: row 0 completed then idle");
  endtask

  initial begin
    test_reset();
    test_frame(8'd127);
    test_frame(8'($urandom_range(0, 255)));
    test_reset_mid_show();
    test_en_drop();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
